// File: rtl/soc_fifo_fwft_wide.sv
// First-word-fall-through FIFO with a one-word write port and a read window of up to
// p_rd_words words. A single cycle can pop any number of words from 0 to p_rd_words.
module soc_fifo_fwft_wide #(
   parameter int unsigned p_data_width   = 8,
   parameter int unsigned p_fifo_depth   = 32,
   parameter int unsigned p_rd_words     = 4,
   parameter int unsigned p_almost_full  = 28,
   parameter int unsigned p_almost_empty = 2
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst,
   input  logic                                 i_flush,
   input  logic                                 i_wr_en,
   input  logic [p_data_width-1:0]              i_wr_data,
   input  logic                                 i_rd_en,
   input  logic [$clog2(p_rd_words):0]          i_rd_cnt,
   output logic [p_data_width*p_rd_words-1:0]   o_rd_data,
   output logic [$clog2(p_fifo_depth):0]        o_level,
   output logic                                 o_empty,
   output logic                                 o_full,
   output logic                                 o_almost_empty,
   output logic                                 o_almost_full,
   output logic                                 o_overflow,
   output logic                                 o_underflow
);

   localparam int unsigned AW = $clog2(p_fifo_depth);
   localparam int unsigned LW = AW + 1;
   localparam int unsigned CW = $clog2(p_rd_words) + 1;

   logic [p_data_width-1:0] mem [p_fifo_depth];
   logic [LW-1:0]           rd_ptr;
   logic [LW-1:0]           wr_ptr;
   logic [LW-1:0]           level;
   logic                    rd_acc;
   logic                    wr_acc;

   assign level = wr_ptr - rd_ptr;

   // Pops are all-or-nothing against the level before this edge; a same-cycle write never helps.
   assign rd_acc = i_rd_en && (i_rd_cnt != '0) && (i_rd_cnt <= CW'(p_rd_words))
                   && (LW'(i_rd_cnt) <= level);
   assign wr_acc = i_wr_en && ((level != LW'(p_fifo_depth)) || rd_acc);

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         if (rd_acc) rd_ptr <= rd_ptr + LW'(i_rd_cnt);
         if (wr_acc) wr_ptr <= wr_ptr + LW'(1);
         o_overflow  <= i_wr_en && !wr_acc;
         o_underflow <= i_rd_en && (i_rd_cnt != '0) && !rd_acc;
      end
   end

   // When full, a write that coincides with a pop reuses the slot just vacated by the head.
   always_ff @(posedge i_clk) begin
      if (wr_acc && !i_rst && !i_flush) mem[wr_ptr[AW-1:0]] <= i_wr_data;
   end

   always_comb begin
      o_rd_data = '0;
      for (int unsigned k = 0; k < p_rd_words; k++) begin
         if (LW'(k) < level)
            o_rd_data[k*p_data_width +: p_data_width] = mem[rd_ptr[AW-1:0] + AW'(k)];
      end
   end

   assign o_level        = level;
   assign o_empty        = (level == '0);
   assign o_full         = (level == LW'(p_fifo_depth));
   assign o_almost_empty = (level <= LW'(p_almost_empty));
   assign o_almost_full  = (level >= LW'(p_almost_full));

endmodule

// File: tb/tb_soc_fifo_fwft_wide.sv
// Self-checking bench for soc_fifo_fwft_wide: directed scenarios plus a random run
// against a queue-based reference model.
module tb_soc_fifo_fwft_wide;

   localparam int DW = 8;
   localparam int DEPTH = 32;
   localparam int RW = 4;
   localparam int AF = 28;
   localparam int AE = 2;

   logic          i_clk = 1'b0;
   logic          i_rst;
   logic          i_flush;
   logic          i_wr_en;
   logic [DW-1:0] i_wr_data;
   logic          i_rd_en;
   logic [2:0]    i_rd_cnt;
   logic [31:0]   o_rd_data;
   logic [5:0]    o_level;
   logic          o_empty, o_full, o_almost_empty, o_almost_full, o_overflow, o_underflow;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] q[$];
   logic          exp_ovf = 1'b0;
   logic          exp_unf = 1'b0;

   soc_fifo_fwft_wide #(
      .p_data_width(DW), .p_fifo_depth(DEPTH), .p_rd_words(RW),
      .p_almost_full(AF), .p_almost_empty(AE)
   ) dut (
      .i_clk(i_clk), .i_rst(i_rst), .i_flush(i_flush),
      .i_wr_en(i_wr_en), .i_wr_data(i_wr_data),
      .i_rd_en(i_rd_en), .i_rd_cnt(i_rd_cnt),
      .o_rd_data(o_rd_data), .o_level(o_level),
      .o_empty(o_empty), .o_full(o_full),
      .o_almost_empty(o_almost_empty), .o_almost_full(o_almost_full),
      .o_overflow(o_overflow), .o_underflow(o_underflow)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] model_window();
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < RW; k++)
         if (k < q.size()) w[k*DW +: DW] = q[k];
      return w;
   endfunction

   // One clock cycle of stimulus; the queue model is updated with the rules of the FIFO.
   task automatic cyc(input logic rst, input logic fl, input logic wr, input logic [DW-1:0] d,
                      input logic rd, input logic [2:0] cnt);
      int  n;
      bit  pa, wa;
      n = q.size();
      i_rst = rst; i_flush = fl; i_wr_en = wr; i_wr_data = d; i_rd_en = rd; i_rd_cnt = cnt;
      pa = rd && (cnt != 0) && (int'(cnt) <= n);
      wa = wr && ((n < DEPTH) || pa);
      @(posedge i_clk);
      if (rst || fl) begin
         q.delete();
         exp_ovf = 1'b0;
         exp_unf = 1'b0;
      end else begin
         if (pa) repeat (int'(cnt)) void'(q.pop_front());
         if (wa) q.push_back(d);
         exp_ovf = wr && !wa;
         exp_unf = rd && (cnt != 0) && !pa;
      end
      #1;
      i_rst = 1'b0; i_flush = 1'b0; i_wr_en = 1'b0; i_rd_en = 1'b0; i_rd_cnt = '0;
   endtask

   task automatic test_reset();
      cyc(1, 0, 0, 0, 0, 0);
      cyc(1, 0, 1, 8'h77, 1, 1);
      checks++; if (o_level !== 6'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", o_level); end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", o_empty); end
      checks++; if (o_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", o_full); end
      checks++; if (o_almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b expected 1", o_almost_empty); end
      checks++; if (o_almost_full !== 1'b0) begin errors++; $display("FAIL reset_afull: got %b expected 0", o_almost_full); end
      checks++; if ({o_overflow, o_underflow} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {o_overflow, o_underflow}); end
      checks++; if (o_rd_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", o_rd_data); end
   endtask

   task automatic test_basic_write();
      cyc(0, 0, 1, 8'h11, 0, 0);
      cyc(0, 0, 1, 8'h22, 0, 0);
      cyc(0, 0, 1, 8'h33, 0, 0);
      checks++; if (o_level !== 6'd3) begin errors++; $display("FAIL basic_level: got %0d expected 3", o_level); end
      checks++; if (o_rd_data !== 32'h00332211) begin errors++; $display("FAIL basic_data: got %h expected 00332211", o_rd_data); end
      checks++; if (o_empty !== 1'b0) begin errors++; $display("FAIL basic_empty: got %b expected 0", o_empty); end
      checks++; if (o_almost_empty !== 1'b0) begin errors++; $display("FAIL basic_aempty: got %b expected 0", o_almost_empty); end
   endtask

   task automatic test_fill_overflow();
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < DEPTH; i++) begin
         cyc(0, 0, 1, DW'(i), 0, 0);
         checks++;
         if (o_almost_full !== (i + 1 >= AF)) begin
            errors++; $display("FAIL fill_afull: level %0d got %b expected %b", i + 1, o_almost_full, (i + 1 >= AF));
         end
      end
      checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL fill_full: got %b expected 1", o_full); end
      cyc(0, 0, 1, 8'hEE, 0, 0);
      checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL ovf_pulse: got %b expected 1", o_overflow); end
      checks++; if (o_level !== 6'd32) begin errors++; $display("FAIL ovf_level: got %0d expected 32", o_level); end
      cyc(0, 0, 0, 0, 0, 0);
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL ovf_single: got %b expected 0", o_overflow); end
   endtask

   task automatic test_full_write_pop();
      cyc(0, 0, 1, 8'hAA, 1, 1);
      checks++; if (o_level !== 6'd32) begin errors++; $display("FAIL fullwp_level: got %0d expected 32", o_level); end
      checks++; if (o_rd_data[7:0] !== 8'd1) begin errors++; $display("FAIL fullwp_head: got %h expected 01", o_rd_data[7:0]); end
      checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL fullwp_ovf: got %b expected 0", o_overflow); end
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1, 4);
      checks++; if (o_rd_data !== 32'hAA1F1E1D) begin errors++; $display("FAIL fullwp_tail: got %h expected AA1F1E1D", o_rd_data); end
      checks++; if (o_level !== 6'd4) begin errors++; $display("FAIL fullwp_level4: got %0d expected 4", o_level); end
   endtask

   task automatic test_wrap();
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 30; i++) cyc(0, 0, 1, DW'(8'h40 + i), 0, 0);
      for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0, 1, 4);
      for (int i = 0; i < 6; i++) cyc(0, 0, 1, DW'(8'h80 + i), 0, 0);
      checks++; if (o_level !== 6'd8) begin errors++; $display("FAIL wrap_level: got %0d expected 8", o_level); end
      checks++; if (o_rd_data !== 32'h81805D5C) begin errors++; $display("FAIL wrap_data: got %h expected 81805D5C", o_rd_data); end
      cyc(0, 0, 0, 0, 1, 2);
      checks++; if (o_rd_data !== 32'h83828180) begin errors++; $display("FAIL wrap_straddle: got %h expected 83828180", o_rd_data); end
      checks++; if (o_level !== 6'd6) begin errors++; $display("FAIL wrap_level6: got %0d expected 6", o_level); end
   endtask

   task automatic test_underflow();
      cyc(0, 1, 0, 0, 0, 0);
      cyc(0, 0, 1, 8'hA1, 0, 0);
      cyc(0, 0, 1, 8'hA2, 0, 0);
      cyc(0, 0, 0, 0, 1, 3);
      checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL unf_pulse: got %b expected 1", o_underflow); end
      checks++; if (o_level !== 6'd2) begin errors++; $display("FAIL unf_level: got %0d expected 2", o_level); end
      checks++; if (o_rd_data !== 32'h0000A2A1) begin errors++; $display("FAIL unf_data: got %h expected 0000A2A1", o_rd_data); end
      cyc(0, 0, 0, 0, 1, 0);
      checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL unf_cnt0: got %b expected 0", o_underflow); end
      cyc(0, 0, 0, 0, 1, 2);
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL unf_empty: got %b expected 1", o_empty); end
      checks++; if (o_rd_data !== 32'h0) begin errors++; $display("FAIL unf_zero: got %h expected 0", o_rd_data); end
      cyc(0, 0, 1, 8'h3C, 1, 1);
      checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL empty_wp_unf: got %b expected 1", o_underflow); end
      checks++; if (o_level !== 6'd1) begin errors++; $display("FAIL empty_wp_level: got %0d expected 1", o_level); end
   endtask

   task automatic test_flush();
      cyc(0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) cyc(0, 0, 1, DW'(i + 1), 0, 0);
      cyc(0, 1, 1, 8'h99, 1, 1);
      checks++; if (o_level !== 6'd0) begin errors++; $display("FAIL flush_level: got %0d expected 0", o_level); end
      checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL flush_empty: got %b expected 1", o_empty); end
      checks++; if ({o_overflow, o_underflow} !== 2'b00) begin errors++; $display("FAIL flush_err: got %b expected 00", {o_overflow, o_underflow}); end
      cyc(0, 0, 1, 8'h5A, 0, 0);
      checks++; if (o_rd_data !== 32'h0000005A) begin errors++; $display("FAIL flush_rewrite: got %h expected 0000005A", o_rd_data); end
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, DW'(i), 0, 0);
      cyc(1, 0, 1, 8'h12, 0, 0);
      checks++; if (o_level !== 6'd0 || o_rd_data !== 32'h0) begin errors++; $display("FAIL rst_midstream: got level %0d data %h expected 0 0", o_level, o_rd_data); end
   endtask

   task automatic test_random();
      logic       wr, rd, fl, rst;
      logic [2:0] cnt;
      for (int c = 0; c < 3000; c++) begin
         wr  = ((c / 300) % 2 == 0) ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 4);
         rd  = ((c / 300) % 2 == 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 8);
         cnt = 3'($urandom_range(0, RW));
         fl  = ($urandom_range(0, 249) == 0);
         rst = ($urandom_range(0, 799) == 0);
         cyc(rst, fl, wr, 8'($urandom), rd, cnt);
         checks++; if (o_level !== 6'(q.size())) begin errors++; $display("FAIL rnd_level @%0d: got %0d expected %0d", c, o_level, q.size()); end
         checks++; if (o_rd_data !== model_window()) begin errors++; $display("FAIL rnd_data @%0d: got %h expected %h", c, o_rd_data, model_window()); end
         checks++;
         if ({o_empty, o_full, o_almost_empty, o_almost_full} !==
             {q.size() == 0, q.size() == DEPTH, q.size() <= AE, q.size() >= AF}) begin
            errors++; $display("FAIL rnd_flags @%0d: got %b expected %b", c, {o_empty, o_full, o_almost_empty, o_almost_full},
                               {q.size() == 0, q.size() == DEPTH, q.size() <= AE, q.size() >= AF});
         end
         checks++; if ({o_overflow, o_underflow} !== {exp_ovf, exp_unf}) begin errors++; $display("FAIL rnd_err @%0d: got %b expected %b", c, {o_overflow, o_underflow}, {exp_ovf, exp_unf}); end
      end
   endtask

   initial begin
      i_rst = 1'b1; i_flush = 1'b0; i_wr_en = 1'b0; i_wr_data = '0; i_rd_en = 1'b0; i_rd_cnt = '0;
      test_reset();
      test_basic_write();
      test_fill_overflow();
      test_full_write_pop();
      test_wrap();
      test_underflow();
      test_flush();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/soc_fifo_fwft_wide.md
# soc_fifo_fwft_wide

First-word-fall-through FIFO with a single-word write side and a variable-width read side. Each cycle the consumer may pop 0 to `p_rd_words` words. The block replaces fixed single/x4 read FIFOs in the SoC datapaths, such as the UART/SPI to instruction-fetch and peripheral bridges. It also adds occupancy reporting, programmable almost-flags, flush, and overflow/underflow error pulses.

## Interface
Parameters:
- `p_data_width`, 8, width of one word
- `p_fifo_depth`, 32, number of entries; power of two, ≥ 2·`p_rd_words`
- `p_rd_words`, 4, maximum words popped per cycle and width of the read window; ≥ 1
- `p_almost_full`, 28, `o_almost_full` asserts when level ≥ this value
- `p_almost_empty`, 2, `o_almost_empty` asserts when level ≤ this value

Ports (`LW` = $clog2(`p_fifo_depth`)+1, `CW` = $clog2(`p_rd_words`)+1):
- `i_clk`  in  1  global clock; single clock domain
- `i_rst`  in  1  global reset, synchronous, active-high
- `i_flush`  in  1  synchronous clear of contents
- `i_wr_en`  in  1  write request
- `i_wr_data`  in  `p_data_width`  write word
- `i_rd_en`  in  1  pop request
- `i_rd_cnt`  in  CW  number of words to pop, 1..`p_rd_words`; 0 means no pop
- `o_rd_data`  out  `p_data_width`·`p_rd_words`  read window; word k is at bits [k·W +: W] and holds entry head+k
- `o_level`  out  LW  current occupancy, 0..`p_fifo_depth`
- `o_empty`  out  1  level == 0
- `o_full`  out  1  level == `p_fifo_depth`
- `o_almost_empty`  out  1  level ≤ `p_almost_empty`
- `o_almost_full`  out  1  level ≥ `p_almost_full`
- `o_overflow`  out  1  one-cycle pulse: write rejected
- `o_underflow`  out  1  one-cycle pulse: pop rejected

## Operation
- State: memory (not reset), `rd_ptr` and `wr_ptr` of LW bits each, with the wrap bit in the MSB. Level = `wr_ptr` − `rd_ptr`, computed modulo 2·depth.
- Pop acceptance: the pop is accepted when `i_rd_en` is high, `i_rd_cnt` is non-zero and `i_rd_cnt` ≤ current level. A same-cycle write does not count towards this level.
  - On acceptance, `rd_ptr` advances by `i_rd_cnt`.
  - On rejection, the FIFO is unchanged and `o_underflow` pulses next cycle. Partial pops never occur.
  - `i_rd_en` with `i_rd_cnt` = 0 is a no-op and does not pulse.
- Write acceptance: the write is accepted when `i_wr_en` is high and either `!o_full` or a pop is accepted in the same cycle.
  - On acceptance, the word is stored at `wr_ptr` and `wr_ptr` advances by 1.
  - On rejection, `o_overflow` pulses next cycle.
- Next level = level + wr_acc − rd_cnt_acc.
- Read window: `o_rd_data` word k = mem[(`rd_ptr`+k) mod depth] if k < level, otherwise 0. The window wraps across the end of memory transparently.
- Flush: `i_flush` has priority over reads and writes. Pointers clear to 0. A same-cycle write or pop is discarded with no error pulse.
- `i_rst` has priority over `i_flush`.
- Simultaneous write and pop when full, with `i_rd_cnt` = 1: both are accepted and level stays at depth.
- Simultaneous write and pop when empty: the pop is rejected with underflow and the write is accepted.

## Timing
- Reset values: `o_level` 0, `o_empty` 1, `o_full` 0, `o_almost_empty` 1, `o_almost_full` 0, `o_overflow` 0, `o_underflow` 0, `o_rd_data` all zero.
- All outputs are functions of registered state only. There is no combinational path from any input to any output.
- Write latency: a word accepted at edge N appears in `o_rd_data` and is counted in `o_level` from edge N (i.e. during cycle N+1).
- A pop accepted at edge N shifts the window by `i_rd_cnt` words from edge N.
- Error pulses are registered: high for exactly the one cycle following the rejected request.
- Throughput: 1 write and up to `p_rd_words` pops per cycle, sustained, with no bubbles.
- Reset or flush asserted mid-stream: from the next cycle the FIFO is empty and all flags take their reset values.

## Test plan
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles -> one cycle after the third write: `o_level` = 3, `o_rd_data` = {0x00, 0x33, 0x22, 0x11}, `o_empty` = 0, `o_almost_empty` = 0.
- Fill 32 words 0..31 -> `o_full` = 1, `o_almost_full` set from level 28 on. A 33rd write without a pop -> `o_overflow` pulses once and `o_level` stays 32.
- Fill 32, then write 0xAA together with `i_rd_cnt` = 1 -> both accepted, `o_level` = 32, window word 0 = 1, and 0xAA is at the tail.
- Wrap-around: write 30, pop 4×7, then write 6 -> level 8. The window straddles entries 30, 31, 0, 1 with the correct data order.
- Level 2, then `i_rd_en` with `i_rd_cnt` = 3 -> `o_underflow` pulse, level stays 2, data unchanged. Then `i_rd_cnt` = 2 -> `o_empty` = 1 and window all zero.
- Level 10, then `i_flush` together with `i_wr_en` and `i_rd_en` -> next cycle: level 0, empty, no error pulses. A subsequent write of 0x5A is visible one cycle later at word 0.
